// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order imem requests, small instruction queue, redirect flush.
// Optional FETCH_BYPASS_EN presents a response straight to decode when the queue is empty.
module fetch_unit #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        validF,
  output logic [31:0] PCF,
  output logic [31:0] PCplus4F,
  output logic [31:0] InstrF
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [CntW:0] occ;
  logic          req_fire, rsp_keep, rsp_drop;
  logic          q_empty, byp_hit, byp_take, enq, deq;
  logic [31:0]   redirect_pc;
  logic          unused_tgt_lsb;

  assign unused_tgt_lsb = ^PCTargetE[1:0];
  assign redirect_pc    = {PCTargetE[31:2], 2'b00};

  // Outstanding requests reserve queue slots so every kept response has room.
  assign occ            = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = !reset && (occ < DepthOcc) && !PCSrcE;
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign q_empty  = (count_q == '0);
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !PCSrcE;

`ifdef FETCH_BYPASS_EN
  assign byp_hit = rsp_keep && q_empty;
`else
  assign byp_hit = 1'b0;
`endif
  assign byp_take = byp_hit && !stallF;
  assign enq      = rsp_keep && !byp_take;
  assign deq      = !q_empty && !stallF;

  always_comb begin
    outst_d    = outst_q + CntW'(req_fire) - CntW'(imem_rsp_valid);
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    if (PCSrcE) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_d     = outst_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
      if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(enq) - CntW'(deq);
      if (rsp_drop) drop_d = drop_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr_q]    <= rsp_pc_q;
      instr_mem[wr_ptr_q] <= imem_rsp_data;
    end
  end

  always_comb begin
    validF = !q_empty;
    PCF    = q_empty ? 32'h0 : pc_mem[rd_ptr_q];
    InstrF = q_empty ? NOP_INSTR : instr_mem[rd_ptr_q];
    if (byp_hit) begin
      validF = 1'b1;
      PCF    = rsp_pc_q;
      InstrF = imem_rsp_data;
    end
  end

  assign PCplus4F = PCF + 32'd4;

`ifndef SYNTHESIS
  a_occupancy: assert property (@(posedge clk) disable iff (reset) occ <= DepthOcc);
  a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
                                   imem_rsp_valid |-> (outst_q != '0));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: memory model with configurable latency.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        validF;
  logic [31:0] PCF, PCplus4F, InstrF;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stallF        (stallF),
    .PCSrcE        (PCSrcE),
    .PCTargetE     (PCTargetE),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .validF        (validF),
    .PCF           (PCF),
    .PCplus4F      (PCplus4F),
    .InstrF        (InstrF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_pop = 0;
  logic        rdy = 1'b1;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] target = 32'h0;
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] last_pc, last_p4;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // One clock cycle: drive inputs at negedge, score handshakes and pops, advance.
  task automatic step();
    req_t        r;
    logic [31:0] e;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    imem_req_ready = rdy;
    stallF         = stall;
    PCSrcE         = redir;
    PCTargetE      = target;
    #1;
    if (redir) begin
      total++;
      if (imem_req_valid !== 1'b0) begin
        bad++;
        $display("FAIL redirect_req_valid got=%b exp=0", imem_req_valid);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      total++;
      if (imem_addr !== exp_fetch) begin
        bad++;
        $display("FAIL req_addr got=%h exp=%h", imem_addr, exp_fetch);
      end
      r.addr = imem_addr;
      r.due  = cyc + lat;
      mem_q.push_back(r);
      exp_q.push_back(exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (validF && !stallF && !redir) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected got_pc=%h exp=none", PCF);
      end else begin
        e = exp_q.pop_front();
        if (PCF !== e || InstrF !== memfn(e) || PCplus4F !== e + 32'd4) begin
          bad++;
          $display("FAIL pop got pc=%h instr=%h pc4=%h exp pc=%h instr=%h pc4=%h",
                   PCF, InstrF, PCplus4F, e, memfn(e), e + 32'd4);
        end
      end
      n_pop++;
      last_pc = PCF;
      last_p4 = PCplus4F;
    end
    if (redir) begin
      exp_q.delete();
      exp_fetch = {target[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_pop(output bit ok);
    int start;
    start = n_pop;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (n_pop != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total += 5;
    if (validF !== 1'b0) begin bad++; $display("FAIL rst_validF got=%b exp=0", validF); end
    if (PCF !== 32'h0) begin bad++; $display("FAIL rst_PCF got=%h exp=0", PCF); end
    if (PCplus4F !== 32'h4) begin bad++; $display("FAIL rst_PCplus4F got=%h exp=4", PCplus4F); end
    if (InstrF !== NOP) begin bad++; $display("FAIL rst_InstrF got=%h exp=%h", InstrF, NOP); end
    if (imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid);
    end
  endtask

  task automatic test_stream();
    int start;
    rdy = 1'b1; stall = 1'b0; lat = 1;
    #1;
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL first_req got=%b/%h exp=1/00000000", imem_req_valid, imem_addr);
    end
    step();
    total++;
    if (validF !== 1'b0) begin bad++; $display("FAIL latency_early got=%b exp=0", validF); end
    step();
    total++;
    if (validF !== 1'b1 || PCF !== 32'h0 || PCplus4F !== 32'h4) begin
      bad++; $display("FAIL latency_first got=%b/%h/%h exp=1/0/4", validF, PCF, PCplus4F);
    end
    start = n_pop;
    for (int i = 0; i < 30; i++) step();
    total++;
    if (n_pop - start < 15) begin
      bad++; $display("FAIL throughput got=%0d exp>=15", n_pop - start);
    end
  endtask

  task automatic test_stall();
    int start;
    stall = 1'b1;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL stall_model got=empty exp=nonempty");
      end else if (imem_req_valid !== 1'b0 || validF !== 1'b1 || PCF !== exp_q[0] ||
                   InstrF !== memfn(exp_q[0])) begin
        bad++;
        $display("FAIL stall_hold got req=%b v=%b pc=%h ins=%h exp req=0 v=1 pc=%h ins=%h",
                 imem_req_valid, validF, PCF, InstrF, exp_q[0], memfn(exp_q[0]));
      end
    end
    stall = 1'b0;
    start = n_pop;
    for (int i = 0; i < 12; i++) step();
    total++;
    if (n_pop - start < 4) begin
      bad++; $display("FAIL stall_release got=%0d exp>=4", n_pop - start);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) step();
    lat = 4; rdy = 1'b1;
    step();
    step();
    redir = 1'b1; target = 32'h0000_0103;
    step();
    redir = 1'b0;
    total++;
    if (validF !== 1'b0) begin bad++; $display("FAIL redirect_flush got=%b exp=0", validF); end
    wait_pop(ok);
    total++;
    if (!ok || last_pc !== 32'h0000_0100) begin
      bad++; $display("FAIL redirect_first_pc got=%h ok=%0d exp=00000100", last_pc, ok);
    end
    lat = 1;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_redirect_rsp();
    bit ok;
    for (int i = 0; i < 10; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) break;
      step();
    end
    total++;
    if (!(mem_q.size() > 0 && mem_q[0].due <= cyc)) begin
      bad++; $display("FAIL redirect_rsp_setup got=no_rsp exp=rsp_pending");
    end
    redir = 1'b1; target = 32'h0000_2000;
    step();
    redir = 1'b0;
    wait_pop(ok);
    total++;
    if (!ok || last_pc !== 32'h0000_2000) begin
      bad++; $display("FAIL redirect_rsp_pc got=%h ok=%0d exp=00002000", last_pc, ok);
    end
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_wrap();
    bit ok;
    redir = 1'b1; target = 32'hFFFF_FFFC;
    step();
    redir = 1'b0;
    wait_pop(ok);
    total++;
    if (!ok || last_pc !== 32'hFFFF_FFFC || last_p4 !== 32'h0) begin
      bad++; $display("FAIL wrap_top got=%h/%h ok=%0d exp=fffffffc/00000000", last_pc, last_p4, ok);
    end
    wait_pop(ok);
    total++;
    if (!ok || last_pc !== 32'h0) begin
      bad++; $display("FAIL wrap_zero got=%h ok=%0d exp=00000000", last_pc, ok);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (validF !== 1'b1) begin bad++; $display("FAIL pre_reset_full got=%b exp=1", validF); end
    reset = 1'b1;
    imem_rsp_valid = 1'b0;
    #1;
    total++;
    if (validF !== 1'b0 || InstrF !== NOP || PCF !== 32'h0 || imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got v=%b ins=%h pc=%h req=%b exp v=0 ins=%h pc=0 req=0",
               validF, InstrF, PCF, imem_req_valid, NOP);
    end
    @(posedge clk);
    @(negedge clk);
    mem_q.delete();
    exp_q.delete();
    exp_fetch = 32'h0;
    stall = 1'b0;
    reset = 1'b0;
    wait_pop(ok);
    total++;
    if (!ok || last_pc !== 32'h0) begin
      bad++; $display("FAIL restart_pc got=%h ok=%0d exp=00000000", last_pc, ok);
    end
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    reset          = 1'b1;
    stallF         = 1'b0;
    PCSrcE         = 1'b0;
    PCTargetE      = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rsp();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
